// File: rtl/osd_pkg.sv
// Shared constants and types for the OSD text-buffer write side.
package osd_pkg;

    localparam int         LOG2TXT   = 8;
    localparam int         WINDOW_W  = 32;
    localparam int         WINDOW_H  = 8;
    localparam logic [7:0] FILL_CHAR = 8'h20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } osd_state_t;

endpackage

// File: rtl/osd_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is requester A, bit 1 is requester B.
// A requester is eligible when its request is high and its mask bit is low.
// The pointer always moves past whoever was granted, so a lone winner also
// hands priority to the other side for the next contention.
module osd_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);

    logic       r_ptr;   // 0: A preferred, 1: B preferred
    logic [1:0] w_elig;

    assign w_elig = i_req & ~i_mask & {2{i_en}};

    // One-hot grant from the eligible set and the pointer.
    always_comb begin
        o_gnt = 2'b00;
        case (w_elig)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // Point at the requester that did not get the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (|o_gnt)
            r_ptr <= o_gnt[0];
    end

endmodule

// File: rtl/osd_textbuf_ctl.sv
// Write-side controller for the OSD text buffer: one write per clock shared
// between the clear engine, cursor port A and random-access port B.
// Optional feature: OSD_AUTOCLEAR_EN -- come out of reset already clearing.
module osd_textbuf_ctl
    import osd_pkg::*;
#(
    parameter int         LOG2TXT   = osd_pkg::LOG2TXT,
    parameter logic [7:0] FILL_CHAR = osd_pkg::FILL_CHAR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    output logic               clear_busy,
    input  logic               a_setpos,
    input  logic [LOG2TXT-1:0] a_pos,
    input  logic               a_req,
    input  logic [7:0]         a_data,
    output logic               a_ack,
    output logic [LOG2TXT-1:0] a_cursor,
    input  logic               b_req,
    input  logic [LOG2TXT-1:0] b_addr,
    input  logic [7:0]         b_data,
    output logic               b_ack,
    output logic [LOG2TXT-1:0] txt_addr,
    output logic [7:0]         txt_data,
    output logic               txt_wren
);

    osd_state_t         r_state, w_state_nxt;
    logic [LOG2TXT:0]   r_cnt, w_cnt_nxt;   // next clear address; MSB marks done
    logic [LOG2TXT-1:0] r_addr, w_addr;
    logic [7:0]         r_data, w_data;
    logic               r_wren, w_wren;
    logic               r_a_ack, r_b_ack;
    logic [LOG2TXT-1:0] r_cursor;
    logic               w_arb_en;
    logic [1:0]         w_gnt;

    // A requester is masked in the cycle its ack is showing, so it cannot be
    // granted again before it has had a chance to present new data.
    osd_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_arb_en),
        .i_req  ({b_req, a_req}),
        .i_mask ({r_b_ack, r_a_ack}),
        .o_gnt  (w_gnt)
    );

    // Next state, clear counter and the write to register for next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wren      = 1'b0;
        w_addr      = r_addr;
        w_data      = r_data;
        w_arb_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    // Issue the address-0 fill on the way in so the first
                    // write lands together with clear_busy.
                    w_state_nxt = ST_CLEAR;
                    w_wren      = 1'b1;
                    w_addr      = '0;
                    w_data      = FILL_CHAR;
                    w_cnt_nxt   = {{LOG2TXT{1'b0}}, 1'b1};
                end else begin
                    w_arb_en = 1'b1;
                    if (w_gnt[0]) begin
                        w_wren = 1'b1;
                        w_addr = r_cursor;
                        w_data = a_data;
                    end else if (w_gnt[1]) begin
                        w_wren = 1'b1;
                        w_addr = b_addr;
                        w_data = b_data;
                    end
                end
            end
            ST_CLEAR: begin
                if (r_cnt[LOG2TXT]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wren    = 1'b1;
                    w_addr    = r_cnt[LOG2TXT-1:0];
                    w_data    = FILL_CHAR;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counter and registered buffer-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef OSD_AUTOCLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_IDLE;
`endif
            r_cnt   <= '0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wren  <= w_wren;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_a_ack <= w_gnt[0];
            r_b_ack <= w_gnt[1];
        end
    end

    // Cursor: a load beats the post-write increment; loads work during clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cursor <= '0;
        else if (a_setpos)
            r_cursor <= a_pos;
        else if (w_gnt[0])
            r_cursor <= r_cursor + 1'b1;
    end

    assign clear_busy = (r_state == ST_CLEAR);
    assign a_ack      = r_a_ack;
    assign b_ack      = r_b_ack;
    assign a_cursor   = r_cursor;
    assign txt_addr   = r_addr;
    assign txt_data   = r_data;
    assign txt_wren   = r_wren;

endmodule

// File: tb/tb_osd_textbuf_ctl.sv
// Testbench for osd_textbuf_ctl: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the write port.
module tb_osd_textbuf_ctl;

`ifdef OSD_AUTOCLEAR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req, clear_busy;
    logic       a_setpos, a_req, a_ack, b_req, b_ack, txt_wren;
    logic [7:0] a_pos, a_data, a_cursor, b_addr, b_data, txt_addr, txt_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    osd_textbuf_ctl dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
        .a_setpos(a_setpos), .a_pos(a_pos), .a_req(a_req), .a_data(a_data),
        .a_ack(a_ack), .a_cursor(a_cursor), .b_req(b_req), .b_addr(b_addr),
        .b_data(b_data), .b_ack(b_ack), .txt_addr(txt_addr), .txt_data(txt_data),
        .txt_wren(txt_wren)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       wren;
        logic [7:0] addr;
        logic [7:0] data;
        logic       aack;
        logic       back;
        logic       busy;
        logic       b_first;  // B has priority at the next contention
        logic [7:0] cur;
        logic [8:0] clr;      // fill address due next; 256 = all written
    } mst_t;

    mst_t m;

    function automatic mst_t mreset();
        mst_t r = '0;
        r.busy = AUTO;
        return r;
    endfunction

    function automatic mst_t mstep(mst_t s);
        mst_t n = s;
        logic ea, eb, take_a;
        n.wren = 1'b0; n.aack = 1'b0; n.back = 1'b0;
        if (s.busy) begin
            if (s.clr < 9'd256) begin
                n.wren = 1'b1; n.addr = s.clr[7:0]; n.data = 8'h20; n.clr = s.clr + 9'd1;
            end else begin
                n.busy = 1'b0;
            end
        end else if (clear_req) begin
            n.busy = 1'b1; n.wren = 1'b1; n.addr = 8'h00; n.data = 8'h20; n.clr = 9'd1;
        end else begin
            ea = a_req && !s.aack;
            eb = b_req && !s.back;
            if (ea || eb) begin
                take_a = ea && (!eb || !s.b_first);
                n.wren = 1'b1;
                if (take_a) begin
                    n.aack = 1'b1; n.addr = s.cur; n.data = a_data; n.b_first = 1'b1;
                end else begin
                    n.back = 1'b1; n.addr = b_addr; n.data = b_data; n.b_first = 1'b0;
                end
            end
        end
        if (a_setpos)    n.cur = a_pos;
        else if (n.aack) n.cur = s.cur + 8'd1;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mreset();
        else       m <= mstep(m);
    end

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("wren",   txt_wren,   m.wren);
            check("addr",   txt_addr,   m.addr);
            check("data",   txt_data,   m.data);
            check("a_ack",  a_ack,      m.aack);
            check("b_ack",  b_ack,      m.back);
            check("busy",   clear_busy, m.busy);
            check("cursor", a_cursor,   m.cur);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (clear_busy && t < 400) begin @(negedge clk); t++; end
        check("idle_wait_bound", clear_busy, 1'b0);
    endtask

    task automatic wait_a_ack(input logic [7:0] ea, input logic [7:0] ed);
        int t = 0;
        do begin @(negedge clk); t++; end while (!a_ack && t < 10);
        check("a_ack_seen", a_ack, 1'b1);
        check("a_wr_addr",  txt_addr, ea);
        check("a_wr_data",  txt_data, ed);
    endtask

    initial begin
        int busy_n, wr_n, back_k, prev, who;
        logic [7:0] letters [3];
        reset = 1'b1; clear_req = 0; a_setpos = 0; a_pos = 0; a_req = 0; a_data = 0;
        b_req = 0; b_addr = 0; b_data = 0;
        repeat (2) @(negedge clk);
        // reset values
        check("rst_wren",   txt_wren, 1'b0);
        check("rst_addr",   txt_addr, 8'h00);
        check("rst_data",   txt_data, 8'h00);
        check("rst_ack",    {a_ack, b_ack}, 2'b00);
        check("rst_cursor", a_cursor, 8'h00);
        check("rst_busy",   clear_busy, AUTO);
        reset = 1'b0;
        if (AUTO) begin
            @(negedge clk);
            check("auto_first_wr",   txt_wren, 1'b1);
            check("auto_first_addr", txt_addr, 8'h00);
        end
        wait_idle();
        repeat (2) @(negedge clk);

        // Clear with a B request raised at clear cycle 5
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        busy_n = 0; wr_n = 0; back_k = -1;
        for (int k = 1; k <= 262; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) check("clr_first_addr", {clear_busy, txt_wren, txt_addr}, {2'b11, 8'h00});
            if (k == 256) check("clr_last_addr", txt_addr, 8'hFF);
            if (clear_busy) busy_n++;
            if (txt_wren && !b_ack) wr_n++;
            if (b_ack && back_k < 0) begin
                back_k = k;
                check("b_after_clr_addr", txt_addr, 8'h10);
                check("b_after_clr_data", txt_data, 8'h41);
                b_req = 1'b0;
            end
            if (k == 5) begin b_req = 1'b1; b_addr = 8'h10; b_data = 8'h41; end
        end
        check("clr_busy_cycles", busy_n, 256);
        check("clr_write_count", wr_n, 256);
        check("b_ack_cycle",     back_k, 258);

        // Stream wrap 254, 255, 0
        a_setpos = 1'b1; a_pos = 8'd254;
        @(negedge clk);
        a_setpos = 1'b0;
        check("setpos_cursor", a_cursor, 8'd254);
        letters[0] = 8'h41; letters[1] = 8'h42; letters[2] = 8'h43;
        a_req = 1'b1; a_data = letters[0];
        wait_a_ack(8'd254, letters[0]); a_data = letters[1];
        wait_a_ack(8'd255, letters[1]); a_data = letters[2];
        wait_a_ack(8'd0,   letters[2]); a_req = 1'b0;
        @(negedge clk);
        check("wrap_cursor",    a_cursor, 8'd1);
        check("wrap_model_cur", m.cur, 8'd1);
        check("wrap_no_dup",    {a_ack, txt_wren}, 2'b00);

        // Setpos/grant collision
        a_setpos = 1'b1; a_pos = 8'd3;
        @(negedge clk);
        a_pos = 8'd40; a_req = 1'b1; a_data = 8'h5A;
        @(negedge clk);
        a_setpos = 1'b0; a_req = 1'b0;
        check("coll_ack",    a_ack, 1'b1);
        check("coll_addr",   txt_addr, 8'd3);
        check("coll_data",   txt_data, 8'h5A);
        check("coll_cursor", a_cursor, 8'd40);
        @(negedge clk);

        // Contention: both held, one write per cycle, strictly alternating
        a_req = 1'b1; b_req = 1'b1; a_data = 8'($urandom); b_data = 8'($urandom); b_addr = 8'h80;
        wr_n = 0; prev = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txt_wren) wr_n++;
            who = a_ack ? 0 : (b_ack ? 1 : 2);
            if (prev >= 0 && who != prev) ; else if (prev >= 0) check("alternate", who, 1 - prev);
            prev = who;
            if (a_ack) a_data = 8'($urandom);
            if (b_ack) begin b_data = 8'($urandom); b_addr = 8'($urandom); end
        end
        check("contention_writes", wr_n, 20);
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            clear_req = ($urandom_range(0, 599) == 0);
            a_setpos  = ($urandom_range(0, 15) == 0);
            a_pos     = 8'($urandom);
            if (!a_req) begin a_req = 1'($urandom); a_data = 8'($urandom); end
            else if (a_ack) begin a_data = 8'($urandom); a_req = ($urandom_range(0, 3) != 0); end
            if (!b_req) begin b_req = 1'($urandom); b_data = 8'($urandom); b_addr = 8'($urandom); end
            else if (b_ack) begin
                b_data = 8'($urandom); b_addr = 8'($urandom); b_req = ($urandom_range(0, 3) != 0);
            end
        end
        clear_req = 0; a_setpos = 0; a_req = 0; b_req = 0;
        @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);

        // Reset in the middle of a clear
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (99) @(negedge clk);
        check("midclr_addr", txt_addr, 8'd99);
        reset = 1'b1;
        #1;
        check("midclr_rst_wren", txt_wren, 1'b0);
        check("midclr_rst_addr", txt_addr, 8'h00);
        check("midclr_rst_busy", clear_busy, AUTO);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if (AUTO) begin
            check("midclr_restart", {txt_wren, txt_addr}, {1'b1, 8'h00});
        end else begin
            wr_n = 0;
            for (int k = 0; k < 20; k++) begin
                if (txt_wren) wr_n++;
                @(negedge clk);
            end
            check("midclr_no_writes", wr_n, 0);
        end
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
